crypt_seq_ctrl: RTL and testbench
=================================

# crypt_seq_ctrl

Sequencer for the programmable LFSR message encryptor: owns the single data-memory port, reads the three configuration bytes, steps a 6-bit LFSR, and streams the padded, encrypted message into the output region. It sits between `top_level`'s start/done handshake and the data memory (`dm1`). It replaces ad-hoc sequencing with a fixed-latency, 2-cycles-per-byte FSM.

## Interface
- `OUT_LEN`, 62: encrypted bytes produced.
- `DST_BASE`, 64: first output address.
- `PRE_MIN`, 7: minimum preamble length.
- `PAD_CHAR`, 8'h5F: preamble/padding character.
- `clk`  in  1  system clock. One clock; all state updates on its rising edge.
- `init_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  level-sampled start request; accepted in IDLE or DONE.
- `done`  out  1  high from completion until the next accepted start or reset.
- `mem_addr`  out  8  memory address.
- `mem_rd_en`  out  1  read strobe; `mem_rdata` is valid the following cycle.
- `mem_wr_en`  out  1  write strobe.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data, 1-cycle synchronous latency.
- `abort`  in  1  present only with `CRYPT_ABORT_EN`.

## Operation
- Memory map (fixed):
  - 0..60: plaintext.
  - 61: pre_length.
  - 62: taps in [5:0].
  - 63: seed in [5:0].
  - 64..125: ciphertext.
- States: IDLE, CFG0, CFG1, CFG2, CFG3, FETCH, XFER, DONE.
- IDLE -> CFG0 on `start`.
- CFG0: read addr 61.
- CFG1: read 62; capture pre_len = max(rdata, PRE_MIN).
- CFG2: read 63; capture taps = rdata[5:0]. Taps are not validated.
- CFG3: capture seed = rdata[5:0]. Seed 0 is replaced by 6'h20. LFSR loads the seed. Byte index n = 0. Go to FETCH.
- FETCH (byte n): if n < pre_len, src = PAD_CHAR and no read. Else read addr n - pre_len; it is always ≤ 54.
- XFER:
  - src = captured PAD_CHAR, or `mem_rdata` if a read was issued.
  - Write addr DST_BASE + n, data {src[7:6], src[5:0] ^ LFSR}.
  - LFSR <= {LFSR[4:0], ^(LFSR & taps)}; n++.
  - Go to FETCH, or to DONE after n = OUT_LEN-1.
- DONE: `done` = 1. `start` -> CFG0, and `done` drops the next cycle.
- `start` while busy (CFG*/FETCH/XFER) is ignored.
- Strobes: `mem_rd_en` and `mem_wr_en` are never both high. Both are low in IDLE/DONE.

## Timing
- Reset values: state IDLE, `done` 0, `mem_rd_en` 0, `mem_wr_en` 0, `mem_addr` 0, `mem_wdata` 0, LFSR 6'h20, n 0.
- Edge numbering: `start` sampled at edge E0. CFG0 occupies E0..E1. First FETCH after E4. Each byte takes exactly 2 cycles.
- `done` rises after edge E0+128 and holds.
- Write of byte n occurs in the cycle after E5+2n.
- `init_n` low mid-operation: IDLE at the next edge, no further writes, `done` 0. Bytes already written stay.
- Outputs are registered from state. No combinational path from `start` to memory strobes.

## Configuration
- `CRYPT_ABORT_EN` defined: adds an `abort` input.
  - `abort` high in any state other than IDLE/DONE -> IDLE at the next edge.
  - No write is issued in that cycle, and `done` stays 0.
  - `abort` in IDLE/DONE is ignored.
  - `abort` has priority over `start`.
- `CRYPT_ABORT_EN` undefined: no `abort` port; behaviour otherwise identical.

## Structure
- `crypt_pkg` holds:
  - the state enum;
  - CFG_PRE_ADDR=61, CFG_TAP_ADDR=62, CFG_SEED_ADDR=63;
  - ZERO_SEED_SUB=6'h20;
  - the LFSR next-state function.
- Sub-module `lfsr6`: inputs `load`, `step`, `seed`, `taps`; output `state`. Same clock and reset as the parent.

## Test plan
- Taps 0x30, seed 0x01, pre 9, plaintext "Mr_Watson...":
  - mem[64] = 0x5E, mem[65] = 0x5D.
  - mem[73] = 'M'^0x18 = 0x55.
  - All 62 bytes match the software model.
- Pre 3 (clamped to 7), taps 0x30, seed 0x01:
  - mem[70] = 0x5F^0x03 = 0x5C.
  - mem[71] = 'M'^0x06 = 0x4B.
- Seed 0x00 -> substituted 0x20: mem[64] = 0x7F.
- Timing:
  - `done` rises exactly 128 cycles after `start` is sampled.
  - `start` pulsed at cycle 40 is ignored.
  - Restart from DONE drops `done` next cycle and reproduces identical output.
- `init_n` low at cycle 50 (byte 22 in flight):
  - IDLE next edge, `done` 0.
  - mem[87..125] untouched.
- With `CRYPT_ABORT_EN`: `abort` at cycle 30 -> IDLE next cycle, no write that cycle; `abort` and `start` in the same IDLE cycle -> stays IDLE.

Source files
------------

// File: rtl/crypt_pkg.sv
// crypt_pkg: shared types and constants for the LFSR message encryptor.
// Holds the sequencer state enum, config addresses and the LFSR step.
package crypt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG0,
    ST_CFG1,
    ST_CFG2,
    ST_CFG3,
    ST_FETCH,
    ST_XFER,
    ST_DONE
  } state_e;

  localparam logic [7:0] CFG_PRE_ADDR  = 8'd61;
  localparam logic [7:0] CFG_TAP_ADDR  = 8'd62;
  localparam logic [7:0] CFG_SEED_ADDR = 8'd63;

  // An all-zero LFSR would lock up, so a zero seed is swapped for this.
  localparam logic [5:0] ZERO_SEED_SUB = 6'h20;

  localparam logic [5:0] LFSR_RST = 6'h20;

  // Shift left, feedback is the parity of the tapped bits.
  function automatic logic [5:0] lfsr_next(
    input logic [5:0] s,
    input logic [5:0] taps
  );
    return {s[4:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/crypt_seq_ctrl_lfsr6.sv
// lfsr6: 6-bit programmable-tap LFSR with synchronous load and step.
// Ports: clk, init_n (sync active-low), load, step, seed, taps, state.
module lfsr6
  import crypt_pkg::*;
(
  input  logic       clk,
  input  logic       init_n,
  input  logic       load,
  input  logic       step,
  input  logic [5:0] seed,
  input  logic [5:0] taps,
  output logic [5:0] state
);

  logic [5:0] state_q;
  logic [5:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = lfsr_next(state_q, taps);
    end
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q <= LFSR_RST;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/crypt_seq_ctrl.sv
// crypt_seq_ctrl: reads 3 config bytes, then streams OUT_LEN padded,
// LFSR-encrypted bytes to DST_BASE, 2 cycles per byte.
// Ports: clk, init_n (sync active-low), start, done, mem_addr,
// mem_rd_en, mem_wr_en, mem_wdata, mem_rdata; abort only when
// CRYPT_ABORT_EN is defined.
module crypt_seq_ctrl
  import crypt_pkg::*;
#(
  parameter int unsigned OUT_LEN  = 62,
  parameter logic [7:0]  DST_BASE = 8'd64,
  parameter int unsigned PRE_MIN  = 7,
  parameter logic [7:0]  PAD_CHAR = 8'h5F
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
`ifdef CRYPT_ABORT_EN
  input  logic       abort,
`endif
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [5:0] LAST_N = 6'(OUT_LEN - 1);
  localparam logic [7:0] PRE_LO = 8'(PRE_MIN);

  state_e     state_q, state_d;
  logic [5:0] n_q, n_d;
  logic [7:0] pre_q, pre_d;
  logic [5:0] taps_q, taps_d;

  logic       lfsr_load;
  logic       lfsr_step;
  logic [5:0] lfsr_s;
  logic [5:0] seed_in;
  logic       pad_sel;
  logic       busy;
  logic       abort_hit;
  logic       abort_in;
  logic [7:0] src;

  assign busy = (state_q != ST_IDLE)
             && (state_q != ST_DONE);

`ifdef CRYPT_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  assign abort_hit = abort_in && busy;

  // Bytes below pre_len are preamble and need no memory read.
  assign pad_sel = {2'b00, n_q} < pre_q;

  assign seed_in = (mem_rdata[5:0] == 6'd0)
                 ? ZERO_SEED_SUB
                 : mem_rdata[5:0];

  assign src = pad_sel ? PAD_CHAR : mem_rdata;

  lfsr6 u_lfsr (
    .clk    (clk),
    .init_n (init_n),
    .load   (lfsr_load),
    .step   (lfsr_step),
    .seed   (seed_in),
    .taps   (taps_q),
    .state  (lfsr_s)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    pre_d     = pre_q;
    taps_d    = taps_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // abort outranks start even though it cannot cancel anything here
        if (start && !abort_in) begin
          state_d = ST_CFG0;
        end
      end
      ST_CFG0: state_d = ST_CFG1;
      ST_CFG1: begin
        pre_d   = (mem_rdata < PRE_LO) ? PRE_LO : mem_rdata;
        state_d = ST_CFG2;
      end
      ST_CFG2: begin
        taps_d  = mem_rdata[5:0];
        state_d = ST_CFG3;
      end
      ST_CFG3: begin
        lfsr_load = 1'b1;
        n_d       = 6'd0;
        state_d   = ST_FETCH;
      end
      ST_FETCH: state_d = ST_XFER;
      ST_XFER: begin
        lfsr_step = 1'b1;
        n_d       = n_q + 6'd1;
        state_d   = (n_q == LAST_N) ? ST_DONE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_d   = ST_IDLE;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q <= ST_IDLE;
      n_q     <= 6'd0;
      pre_q   <= PRE_LO;
      taps_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      pre_q   <= pre_d;
      taps_q  <= taps_d;
    end
  end

  // Memory controls decode only registered state, so start never
  // reaches the strobes in the same cycle. Write data must merge the
  // read returned during XFER, so it is combinational from mem_rdata.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    unique case (state_q)
      ST_CFG0: begin
        mem_rd_en = 1'b1;
        mem_addr  = CFG_PRE_ADDR;
      end
      ST_CFG1: begin
        mem_rd_en = 1'b1;
        mem_addr  = CFG_TAP_ADDR;
      end
      ST_CFG2: begin
        mem_rd_en = 1'b1;
        mem_addr  = CFG_SEED_ADDR;
      end
      ST_FETCH: begin
        if (!pad_sel) begin
          mem_rd_en = 1'b1;
          mem_addr  = {2'b00, n_q} - pre_q;
        end
      end
      ST_XFER: begin
        mem_wr_en = !abort_hit;
        mem_addr  = DST_BASE + {2'b00, n_q};
        mem_wdata = {src[7:6], src[5:0] ^ lfsr_s};
      end
      default: ;
    endcase
  end

  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_crypt_seq_ctrl.sv
// tb_crypt_seq_ctrl: self-checking bench for crypt_seq_ctrl.
// Models dm1 and checks ciphertext, write timing and done timing.
module tb_crypt_seq_ctrl;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'd0;

  always #5 clk = ~clk;

  crypt_seq_ctrl dut (
    .clk       (clk),
    .init_n    (init_n),
    .start     (start),
`ifdef CRYPT_ABORT_EN
    .abort     (abort),
`endif
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] mem [256];
  logic [7:0] init_mem [256];
  bit         seen [256];
  int         wr_at [256];
  int         cyc = 0;
  int         both_hi = 0;
  bit         load_req = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_req) begin
      mem <= init_mem;
      for (int i = 0; i < 256; i++) seen[i] <= 1'b0;
    end else if (mem_wr_en) begin
      mem[mem_addr]   <= mem_wdata;
      seen[mem_addr]  <= 1'b1;
      wr_at[mem_addr] <= cyc;
    end
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_rd_en && mem_wr_en) both_hi <= both_hi + 1;
  end

  int         errs = 0;
  int         checks = 0;
  logic [7:0] pt [61];
  logic [7:0] exp_ct [62];

  // Reference: preamble of PAD then plaintext, low 6 bits XOR LFSR.
  function automatic void model(input int pre_raw,
                                input logic [7:0] tp,
                                input logic [7:0] sd);
    int         pre;
    logic [5:0] s;
    logic [7:0] b;
    pre = (pre_raw < 7) ? 7 : pre_raw;
    s = (sd[5:0] == 6'd0) ? 6'h20 : sd[5:0];
    for (int n = 0; n < 62; n++) begin
      b = (n < pre) ? 8'h5F : pt[n - pre];
      exp_ct[n] = {b[7:6], b[5:0] ^ s};
      s = {s[4:0], ^(s & tp[5:0])};
    end
  endfunction

  task automatic setup(input int pre, input logic [7:0] tp,
                       input logic [7:0] sd);
    for (int i = 0; i < 256; i++) init_mem[i] = 8'hEE;
    for (int i = 0; i < 61; i++) init_mem[i] = pt[i];
    init_mem[61] = 8'(pre);
    init_mem[62] = tp;
    init_mem[63] = sd;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    model(pre, tp, sd);
  endtask

  task automatic kick(output int e0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e0 = cyc - 1;
  endtask

  task automatic wait_done(input string tag, input int e0);
    int rise;
    rise = -1;
    for (int k = 0; k < 300 && rise < 0; k++) begin
      @(posedge clk); #1;
      if (done) rise = cyc - 1;
    end
    checks++;
    if (rise != e0 + 128)
      $display("FAIL %s done_edge: got %0d want %0d",
               tag, rise - e0, 128);
  endtask

  task automatic check_out(input string tag, input int e0);
    for (int n = 0; n < 62; n++) begin
      checks++;
      if (mem[64+n] !== exp_ct[n]) begin
        errs++;
        $display("FAIL %s byte%0d: got %02h want %02h",
                 tag, n, mem[64+n], exp_ct[n]);
      end
      checks++;
      if (!seen[64+n] || wr_at[64+n] != e0 + 6 + 2*n) begin
        errs++;
        $display("FAIL %s wr_time%0d: got %0d want %0d",
                 tag, n, wr_at[64+n] - e0, 6 + 2*n);
      end
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got,
                      input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %02h want %02h", tag, got, want);
    end
  endtask

  task automatic load_text();
    string s;
    s = "Mr_Watson, come here. I want to see you.";
    for (int i = 0; i < 61; i++)
      pt[i] = (i < s.len()) ? s[i] : 8'h2E;
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk8("rst_done", {7'd0, done}, 8'd0);
    chk8("rst_rd", {7'd0, mem_rd_en}, 8'd0);
    chk8("rst_wr", {7'd0, mem_wr_en}, 8'd0);
    chk8("rst_addr", mem_addr, 8'd0);
    chk8("rst_wdata", mem_wdata, 8'd0);
    init_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vector();
    int e0;
    load_text();
    setup(9, 8'h30, 8'h01);
    kick(e0);
    wait_done("vec", e0);
    check_out("vec", e0);
    chk8("vec_m64", mem[64], 8'h5E);
    chk8("vec_m65", mem[65], 8'h5D);
    chk8("vec_m73", mem[73], 8'h55);
  endtask

  task automatic test_clamp();
    int e0;
    load_text();
    setup(3, 8'h30, 8'h01);
    kick(e0);
    wait_done("clamp", e0);
    check_out("clamp", e0);
    chk8("clamp_m70", mem[70], 8'h5C);
    chk8("clamp_m71", mem[71], 8'h4B);
  endtask

  task automatic test_zero_seed();
    int e0;
    load_text();
    setup(9, 8'h30, 8'h00);
    kick(e0);
    wait_done("zseed", e0);
    check_out("zseed", e0);
    chk8("zseed_m64", mem[64], 8'h7F);
  endtask

  task automatic test_busy_start();
    int e0;
    load_text();
    setup(12, 8'h21, 8'h2B);
    kick(e0);
    repeat (39) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy", e0);
    check_out("busy", e0);
  endtask

  task automatic test_restart();
    int e0;
    setup(12, 8'h21, 8'h2B);
    chk8("rs_done_hold", {7'd0, done}, 8'd1);
    kick(e0);
    chk8("rs_done_drop", {7'd0, done}, 8'd0);
    wait_done("restart", e0);
    check_out("restart", e0);
  endtask

  task automatic test_mid_reset();
    int e0;
    load_text();
    setup(9, 8'h30, 8'h01);
    kick(e0);
    repeat (49) @(posedge clk);
    #1;
    init_n = 1'b0;
    @(posedge clk); #1;
    chk8("mr_done", {7'd0, done}, 8'd0);
    chk8("mr_wr", {7'd0, mem_wr_en}, 8'd0);
    chk8("mr_rd", {7'd0, mem_rd_en}, 8'd0);
    init_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    for (int n = 0; n < 22; n++)
      chk8($sformatf("mr_kept%0d", n), mem[64+n], exp_ct[n]);
    for (int a = 87; a < 126; a++)
      chk8($sformatf("mr_untouched%0d", a),
           {7'd0, seen[a]}, 8'd0);
  endtask

  task automatic test_random();
    int e0;
    int pre;
    logic [7:0] tp, sd;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 61; i++) pt[i] = 8'($urandom);
      pre = (r == 0) ? 70 : int'($urandom_range(0, 40));
      tp = 8'($urandom);
      sd = (r == 1) ? 8'hC0 : 8'($urandom);
      setup(pre, tp, sd);
      kick(e0);
      wait_done($sformatf("rnd%0d", r), e0);
      check_out($sformatf("rnd%0d", r), e0);
    end
  endtask

`ifdef CRYPT_ABORT_EN
  task automatic test_abort();
    int e0;
    load_text();
    setup(9, 8'h30, 8'h01);
    kick(e0);
    repeat (29) @(posedge clk);
    #1;
    abort = 1'b1;
    #1;
    chk8("ab_nowr", {7'd0, mem_wr_en}, 8'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk8("ab_done", {7'd0, done}, 8'd0);
    chk8("ab_idle_rd", {7'd0, mem_rd_en}, 8'd0);
    chk8("ab_b11", {7'd0, seen[75]}, 8'd1);
    chk8("ab_b12", {7'd0, seen[76]}, 8'd0);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk8("ab_start_rd", {7'd0, mem_rd_en}, 8'd0);
    chk8("ab_start_done", {7'd0, done}, 8'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_vector();
    test_clamp();
    test_zero_seed();
    test_busy_start();
    test_restart();
    test_mid_reset();
    test_random();
`ifdef CRYPT_ABORT_EN
    test_abort();
`endif
    checks++;
    if (both_hi != 0) begin
      errs++;
      $display("FAIL strobe_overlap: got %0d want 0", both_hi);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
